apb_slave_mem: RTL and testbench
================================

Name: apb_slave_mem

Overview:
- Synthesizable APB4 completer with a byte-addressable memory; the DUT-side consumer of the APB master bus driven by the master agent.
- Decodes its own bit of the one-hot pselx bus and services reads and writes with byte strobes.
- Inserts a programmable number of wait states and flags slave errors.
- Uses the same widths, slave encoding, IDLE/SETUP/ACCESS state names and little-endian byte ordering as apb_global_pkg, so slave-agent monitors and scoreboards check it directly.

Parameters:
- NO_OF_SLAVES, 4, width of pselx.
- SLAVE_ID, 0, index of the pselx bit this instance answers to (0..NO_OF_SLAVES-1).
- ADDRESS_WIDTH, 32, paddr width.
- DATA_WIDTH, 32, pwdata/prdata width (8, 16 or 32); strobe width SW = DATA_WIDTH/8.
- MIN_ADDRESS, 32'h0000_0000, first byte address owned.
- MAX_ADDRESS, 32'h0000_03FF, last byte address owned; memory depth = MAX_ADDRESS-MIN_ADDRESS+1 bytes.
- SECURE_ONLY, 0, when 1 a non-secure access (pprot[1]=1) is rejected with an error.

Ports:
- pclk  in  1  APB clock; all logic on rising edge.
- preset  in  1  synchronous active-high reset.
- pselx  in  NO_OF_SLAVES  one-hot slave select.
- penable  in  1  access phase.
- pwrite  in  1  1=WRITE, 0=READ.
- paddr  in  ADDRESS_WIDTH  byte address.
- pwdata  in  DATA_WIDTH  write data.
- pstrb  in  SW  write byte-lane enables.
- pprot  in  3  protection type.
- wait_states_i  in  4  wait states for the next transfer; sampled at SETUP.
- pready  out  1  transfer complete, registered.
- prdata  out  DATA_WIDTH  read data, registered.
- pslverr  out  1  error response, registered.

Behaviour:
- Reset (preset=1 at a pclk edge):
  - state=IDLE, pready=0, pslverr=0, prdata=0, wait counter=0.
  - Memory contents are not cleared.
- Selection: sel = pselx[SLAVE_ID]; other bits are ignored.
- FSM encoding is IDLE=0, SETUP=1, ACCESS=2.
  - IDLE: sel && !penable -> SETUP. Capture addr, pwrite, pwdata, pstrb, pprot; cnt <= wait_states_i; err <= error check.
  - SETUP: sel && penable -> ACCESS. !sel -> IDLE, with no effect.
  - ACCESS, cnt>0: cnt decrements each cycle, pready=0.
  - ACCESS, cnt==0: transfer completes.
  - Any cycle in ACCESS with sel=0 or penable=0 before completion aborts to IDLE: no memory update, pready/pslverr stay 0.
- pready timing: registered so that it is 1 on ACCESS cycle number wait_states_i+1.
  - Zero wait states: pready=1 in the first ACCESS cycle.
  - pready is high for exactly one cycle; pslverr and prdata are valid only in that cycle and 0 otherwise.
- Completion: on the edge where sel && penable && pready are sampled:
  - Write without error: for each lane i with pstrb[i]=1, mem[off+i] <= pwdata[8i+7:8i], where off = addr-MIN_ADDRESS.
  - Next state is IDLE; if sel && !penable is sampled on the completion cycle's following edge, that is a new SETUP (back-to-back).
- Read data: prdata = {mem[off+SW-1],...,mem[off]} (little endian), loaded on the same edge pready is loaded. pstrb is ignored for reads.
- Error check (err=1 if any of the following):
  - addr < MIN_ADDRESS.
  - addr+SW-1 > MAX_ADDRESS.
  - addr not SW-aligned.
  - SECURE_ONLY && pprot[1].
- On error: pslverr=1 with pready, memory unchanged, prdata=0. Wait states are still honoured.
- Write and read of the same word in consecutive transfers: the read returns the newly written data.
- Reset mid-transfer: FSM returns to IDLE next edge and the pending write is dropped.
- wait_states_i changing during ACCESS has no effect on the current transfer.

Test Plan:
- Write 32'hA5A5_1234 to 32'h10 with pstrb=4'hF and wait=0, then read 32'h10 → pready=1 in the first ACCESS cycle of both transfers, pslverr=0, prdata=32'hA5A5_1234.
- Write 32'hFFFF_FFFF to 32'h10 with pstrb=4'b0101, then read 32'h10 → prdata=32'hA5FF_12FF.
- Read with wait=3 → pready=0 for 3 ACCESS cycles and 1 in the 4th; penable held throughout; pready high for 1 cycle only.
- Write to 32'h400, then to 32'h3FE (misaligned), then with SECURE_ONLY=1 and pprot=3'b010 → pslverr=1 with pready each time; a readback of 32'h3FC is unchanged.
- Drive pselx=4'b0010 while SLAVE_ID=0 → pready, pslverr and prdata stay 0; memory unchanged.
- Assert preset during the 2nd wait cycle of a write (wait=5) → next edge state=IDLE and pready=0; a subsequent read returns the old data.

Source files
------------

// File: rtl/apb_slave_mem.sv
// APB4 completer backed by a byte-addressable memory, with programmable wait states,
// byte strobes, range/alignment/protection error reporting and one-hot select decode.
module apb_slave_mem #(
  parameter int unsigned              NO_OF_SLAVES  = 4,
  parameter int unsigned              SLAVE_ID      = 0,
  parameter int unsigned              ADDRESS_WIDTH = 32,
  parameter int unsigned              DATA_WIDTH    = 32,
  parameter logic [ADDRESS_WIDTH-1:0] MIN_ADDRESS   = '0,
  parameter logic [ADDRESS_WIDTH-1:0] MAX_ADDRESS   = ADDRESS_WIDTH'(32'h0000_03FF),
  parameter bit                       SECURE_ONLY   = 1'b0
) (
  input  logic                      pclk,
  input  logic                      preset,
  input  logic [NO_OF_SLAVES-1:0]   pselx,
  input  logic                      penable,
  input  logic                      pwrite,
  input  logic [ADDRESS_WIDTH-1:0]  paddr,
  input  logic [DATA_WIDTH-1:0]     pwdata,
  input  logic [DATA_WIDTH/8-1:0]   pstrb,
  input  logic [2:0]                pprot,
  input  logic [3:0]                wait_states_i,
  output logic                      pready,
  output logic [DATA_WIDTH-1:0]     prdata,
  output logic                      pslverr
);

  localparam int unsigned AW    = ADDRESS_WIDTH;
  localparam int unsigned SW    = DATA_WIDTH / 8;
  localparam int unsigned LSB   = (SW > 1) ? $clog2(SW) : 0;
  localparam int unsigned DEPTH = 32'(MAX_ADDRESS - MIN_ADDRESS) + 32'd1;
  localparam int unsigned WORDS = DEPTH / SW;
  localparam int unsigned WW    = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic                  sel;
  logic                  capture, load_resp, dec, complete, mem_we;
  logic [AW:0]           off_full, end_addr;
  logic                  addr_err;
  logic                  write_q, err_q;
  logic [WW-1:0]         widx_q;
  logic [DATA_WIDTH-1:0] wdata_q, rd_word;
  logic [SW-1:0]         strb_q;
  logic [3:0]            cnt_q;
  logic                  unused_bits;

  assign sel = pselx[SLAVE_ID];

  // Borrow out of the subtraction flags addresses below the window.
  assign off_full = {1'b0, paddr} - {1'b0, MIN_ADDRESS};
  assign end_addr = {1'b0, paddr} + (AW+1)'(SW - 1);

  assign addr_err = off_full[AW]
                  | (end_addr > {1'b0, MAX_ADDRESS})
                  | ((paddr & AW'(SW - 1)) != '0)
                  | (SECURE_ONLY & pprot[1]);

  assign unused_bits = ^{pselx, pprot, off_full};

  always_comb begin
    state_d   = state_q;
    capture   = 1'b0;
    load_resp = 1'b0;
    dec       = 1'b0;
    complete  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (sel && !penable) begin
          state_d = SETUP;
          capture = 1'b1;
        end
      end
      SETUP: begin
        if (sel && penable) begin
          state_d   = ACCESS;
          load_resp = (cnt_q == 4'd0);
        end else if (!sel) begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        if (!sel || !penable) begin
          state_d = IDLE;
        end else if (pready) begin
          complete = 1'b1;
          state_d  = IDLE;
        end else begin
          // pready is registered, so it is loaded one edge before the final ACCESS cycle.
          dec       = (cnt_q != 4'd0);
          load_resp = (cnt_q <= 4'd1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      pready  <= 1'b0;
      pslverr <= 1'b0;
      prdata  <= '0;
      cnt_q   <= 4'd0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
      widx_q  <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
    end else begin
      pready  <= load_resp;
      pslverr <= load_resp & err_q;
      prdata  <= (load_resp && !err_q && !write_q) ? rd_word : '0;
      if (capture) begin
        write_q <= pwrite;
        err_q   <= addr_err;
        widx_q  <= off_full[LSB +: WW];
        wdata_q <= pwdata;
        strb_q  <= pstrb;
        cnt_q   <= wait_states_i;
      end else if (dec) begin
        cnt_q <= cnt_q - 4'd1;
      end
    end
  end

  assign mem_we = complete & write_q & ~err_q & ~preset;

  // Error-free accesses are always aligned, so memory is kept as one bank per byte lane.
  for (genvar g = 0; g < SW; g++) begin : g_lane
    logic [7:0] bank [WORDS];

    always_ff @(posedge pclk) begin
      if (mem_we && strb_q[g]) begin
        bank[widx_q] <= wdata_q[8*g +: 8];
      end
    end

    assign rd_word[8*g +: 8] = bank[widx_q];
  end

endmodule

// File: tb/tb_apb_slave_mem.sv
// Directed bench for apb_slave_mem: a driver queues expected responses, a negedge
// monitor pairs them with pready pulses and checks idle outputs in between.
module tb_apb_slave_mem;

  logic        pclk = 1'b0;
  logic        preset;
  logic [3:0]  pselx;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;
  logic [3:0]  wait_states_i;

  logic        pready0, pslverr0, pready2, pslverr2;
  logic [31:0] prdata0, prdata2;

  always #5 pclk = ~pclk;

  apb_slave_mem #(
    .SLAVE_ID    (0),
    .SECURE_ONLY (1'b0)
  ) u_dut0 (
    .pclk          (pclk),
    .preset        (preset),
    .pselx         (pselx),
    .penable       (penable),
    .pwrite        (pwrite),
    .paddr         (paddr),
    .pwdata        (pwdata),
    .pstrb         (pstrb),
    .pprot         (pprot),
    .wait_states_i (wait_states_i),
    .pready        (pready0),
    .prdata        (prdata0),
    .pslverr       (pslverr0)
  );

  apb_slave_mem #(
    .SLAVE_ID    (2),
    .SECURE_ONLY (1'b1)
  ) u_dut2 (
    .pclk          (pclk),
    .preset        (preset),
    .pselx         (pselx),
    .penable       (penable),
    .pwrite        (pwrite),
    .paddr         (paddr),
    .pwdata        (pwdata),
    .pstrb         (pstrb),
    .pprot         (pprot),
    .wait_states_i (wait_states_i),
    .pready        (pready2),
    .prdata        (prdata2),
    .pslverr       (pslverr2)
  );

  typedef struct {
    int          dut;
    bit          err;
    bit          chk_data;
    logic [31:0] rdata;
    int          cycles;
  } exp_t;

  exp_t exp_q[$];
  int   compared   = 0;
  int   mismatched = 0;
  bit   mon_en     = 1'b0;
  int   acc_cnt    = 0;
  bit   prev_rdy [2];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic rdy_of(input int d);
    case (d)
      0:       return pready0;
      2:       return pready2;
      default: return 1'b0;
    endcase
  endfunction

  // Monitor: slot 0 is u_dut0 (pselx bit 0), slot 1 is u_dut2 (pselx bit 2).
  logic        m_r, m_e;
  logic [31:0] m_d;
  int          m_id;
  exp_t        m_x;
  always @(negedge pclk) begin
    if (mon_en) begin
      for (int s = 0; s < 2; s++) begin
        m_r  = (s == 0) ? pready0  : pready2;
        m_e  = (s == 0) ? pslverr0 : pslverr2;
        m_d  = (s == 0) ? prdata0  : prdata2;
        m_id = (s == 0) ? 0 : 2;
        if (m_r) begin
          check($sformatf("pready_single_cycle_dut%0d", m_id), 64'(prev_rdy[s]), 64'd0);
          if (exp_q.size() == 0) begin
            check($sformatf("unexpected_pready_dut%0d", m_id), 64'd1, 64'd0);
          end else begin
            m_x = exp_q.pop_front();
            check("responder", 64'(m_id), 64'(m_x.dut));
            check("pslverr", 64'(m_e), 64'(m_x.err));
            if (m_x.chk_data) check("prdata", 64'(m_d), 64'(m_x.rdata));
            check("penable_cycles_before_pready", 64'(acc_cnt), 64'(m_x.cycles));
          end
        end else begin
          check($sformatf("idle_outputs_dut%0d", m_id), {31'd0, m_e, m_d}, 64'd0);
        end
        prev_rdy[s] = m_r;
      end
      if (pready0 || pready2 || !penable) acc_cnt = 0;
      else acc_cnt++;
    end
  end

  // One APB transfer. The completer spends one penable cycle in its SETUP state
  // before ACCESS, so pready follows ws+1 penable-high cycles without pready.
  task automatic xfer(input int d, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] sb, input logic [2:0] pr, input int ws,
                      input bit exp_err, input logic [31:0] exp_rd, input bit expect_resp);
    exp_t x;
    bit   got;
    if (expect_resp) begin
      x.dut = d; x.err = exp_err; x.chk_data = !wr; x.rdata = exp_rd; x.cycles = ws + 1;
      exp_q.push_back(x);
    end
    @(posedge pclk); #1;
    pselx = 4'b0001 << d; penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd;
    pstrb = sb; pprot = pr; wait_states_i = 4'(ws);
    @(posedge pclk); #1;
    penable = 1'b1;
    wait_states_i = ~4'(ws);
    if (expect_resp) begin
      got = 1'b0;
      for (int k = 0; k < 40 && !got; k++) begin
        @(negedge pclk);
        if (rdy_of(d)) got = 1'b1;
      end
      if (!got) check("handshake_timeout", 64'd0, 64'd1);
    end else begin
      repeat (6) @(negedge pclk);
    end
    @(posedge pclk); #1;
    pselx = 4'b0; penable = 1'b0;
  endtask

  initial begin
    preset = 1'b1; pselx = 4'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0;
    pwdata = '0; pstrb = '0; pprot = '0; wait_states_i = '0;
    repeat (3) @(posedge pclk);
    #1 preset = 1'b0;
    @(negedge pclk);
    check("reset_pready0", 64'(pready0), 64'd0);
    check("reset_pslverr0", 64'(pslverr0), 64'd0);
    check("reset_prdata0", 64'(prdata0), 64'd0);
    check("reset_pready2", 64'(pready2), 64'd0);
    mon_en = 1'b1;

    // Full-word write/read, then strobed write.
    xfer(0, 1, 32'h10, 32'hA5A5_1234, 4'hF, 3'b000, 0, 0, 32'h0, 1);
    xfer(0, 0, 32'h10, 32'h0, 4'h0, 3'b000, 0, 0, 32'hA5A5_1234, 1);
    xfer(0, 1, 32'h10, 32'hFFFF_FFFF, 4'b0101, 3'b000, 1, 0, 32'h0, 1);
    xfer(0, 0, 32'h10, 32'h0, 4'h0, 3'b000, 0, 0, 32'hA5FF_12FF, 1);
    xfer(0, 0, 32'h10, 32'h0, 4'h0, 3'b000, 3, 0, 32'hA5FF_12FF, 1);

    // Range, alignment and protection errors.
    xfer(0, 1, 32'h3FC, 32'hCAFE_F00D, 4'hF, 3'b000, 0, 0, 32'h0, 1);
    xfer(0, 1, 32'h400, 32'h1234_5678, 4'hF, 3'b000, 0, 1, 32'h0, 1);
    xfer(0, 1, 32'h3FE, 32'h1234_5678, 4'hF, 3'b000, 2, 1, 32'h0, 1);
    xfer(0, 0, 32'h400, 32'h0, 4'h0, 3'b000, 1, 1, 32'h0, 1);
    xfer(2, 1, 32'h3FC, 32'h0BAD_BEEF, 4'hF, 3'b000, 0, 0, 32'h0, 1);
    xfer(2, 1, 32'h3FC, 32'h1111_1111, 4'hF, 3'b010, 0, 1, 32'h0, 1);
    xfer(2, 0, 32'h3FC, 32'h0, 4'h0, 3'b010, 0, 1, 32'h0, 1);
    xfer(2, 0, 32'h3FC, 32'h0, 4'h0, 3'b000, 0, 0, 32'h0BAD_BEEF, 1);
    xfer(0, 0, 32'h3FC, 32'h0, 4'h0, 3'b000, 0, 0, 32'hCAFE_F00D, 1);

    // Select bit 1 belongs to neither instance.
    xfer(1, 1, 32'h3FC, 32'h0, 4'hF, 3'b000, 0, 0, 32'h0, 0);
    xfer(0, 0, 32'h3FC, 32'h0, 4'h0, 3'b000, 0, 0, 32'hCAFE_F00D, 1);

    // Reset during the second wait cycle of a 5-wait write.
    @(posedge pclk); #1;
    pselx = 4'b0001; penable = 1'b0; pwrite = 1'b1; paddr = 32'h10;
    pwdata = 32'h1111_1111; pstrb = 4'hF; pprot = 3'b000; wait_states_i = 4'd5;
    @(posedge pclk); #1 penable = 1'b1;
    @(posedge pclk); #1;
    @(posedge pclk); #1 preset = 1'b1;
    @(posedge pclk); #1 preset = 1'b0;
    check("pready_after_reset", 64'(pready0), 64'd0);
    pselx = 4'b0; penable = 1'b0;
    xfer(0, 0, 32'h10, 32'h0, 4'h0, 3'b000, 0, 0, 32'hA5FF_12FF, 1);

    for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(negedge pclk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    repeat (2) @(negedge pclk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
